// File: rtl/uart_fifo_core.sv
// Buffered UART: TX FIFO, start/data/stop transmitter and oversampled receiver.
// Optional even parity in both directions when UART_PARITY_EN is defined.
module uart_fifo_core #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           baud_sel,
  input  logic                 wr_i,
  input  logic [DATA_BITS-1:0] dat_i,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_busy,
  output logic                 rx_err
);

  localparam int unsigned AW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0]    FULL_CNT = TX_DEPTH[AW:0];

  function automatic int unsigned calc_div(input int unsigned rate);
    int unsigned d;
    d = CLK_HZ / (rate * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

  localparam logic [31:0] DIV_1200   = calc_div(1200);
  localparam logic [31:0] DIV_2400   = calc_div(2400);
  localparam logic [31:0] DIV_4800   = calc_div(4800);
  localparam logic [31:0] DIV_9600   = calc_div(9600);
  localparam logic [31:0] DIV_19200  = calc_div(19200);
  localparam logic [31:0] DIV_38400  = calc_div(38400);
  localparam logic [31:0] DIV_57600  = calc_div(57600);
  localparam logic [31:0] DIV_115200 = calc_div(115200);
  localparam logic [31:0] DIV_230400 = calc_div(230400);
  localparam logic [31:0] DIV_460800 = calc_div(460800);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t r_tx_state, r_rx_state;

  // ---------------- baud select and tick generator ----------------
  logic [3:0]  r_baud;
  logic [31:0] w_div;
  logic [31:0] r_div_cnt;
  logic        w_tick;

  always_comb begin
    w_div = DIV_9600;
    case (r_baud)
      4'd0:    w_div = DIV_1200;
      4'd1:    w_div = DIV_2400;
      4'd2:    w_div = DIV_4800;
      4'd3:    w_div = DIV_9600;
      4'd4:    w_div = DIV_19200;
      4'd5:    w_div = DIV_38400;
      4'd6:    w_div = DIV_57600;
      4'd7:    w_div = DIV_115200;
      4'd8:    w_div = DIV_230400;
      4'd9:    w_div = DIV_460800;
      default: w_div = DIV_9600;
    endcase
  end

  // >= keeps the counter bounded when a smaller divisor is selected mid-count
  assign w_tick = (r_div_cnt >= w_div - 32'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_baud    <= 4'd3;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 32'd1;
      if (r_tx_state == IDLE && r_rx_state == IDLE)
        r_baud <= baud_sel;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_mem [TX_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_cnt;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [DATA_BITS-1:0] w_fifo_dout;

  assign w_full      = (r_cnt == FULL_CNT);
  assign w_empty     = (r_cnt == '0);
  assign w_push      = wr_i & ~w_full;
  assign w_fifo_dout = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= dat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [OSW-1:0]       r_tx_tcnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_tx_arm;
  logic                 r_tx;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = w_tick & (r_tx_tcnt == OS_LAST);
  assign w_pop = ~w_empty & ((r_tx_state == IDLE) |
                             ((r_tx_state == STOP) & w_tx_bit_end));

`ifdef UART_PARITY_EN
  logic r_tx_par;
  always_ff @(posedge clk) begin
    if (!rst)
      r_tx_par <= 1'b0;
    else if (w_pop)
      r_tx_par <= ^w_fifo_dout;
  end
`endif

  // r_tx_arm holds a freshly popped frame until the next tick so the start bit
  // is a full OVERSAMPLE ticks long; back-to-back frames skip the wait.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= IDLE;
      r_tx       <= 1'b1;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_arm   <= 1'b0;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_sh    <= w_fifo_dout;
            r_tx_arm   <= 1'b1;
            r_tx_tcnt  <= '0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tx_arm) begin
              r_tx_arm  <= 1'b0;
              r_tx      <= 1'b0;
              r_tx_tcnt <= '0;
            end else if (r_tx_tcnt == OS_LAST) begin
              r_tx_tcnt  <= '0;
              r_tx       <= r_tx_sh[0];
              r_tx_sh    <= r_tx_sh >> 1;
              r_tx_bit   <= '0;
              r_tx_state <= DATA;
            end else begin
              r_tx_tcnt <= r_tx_tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tx_bit_end) begin
            r_tx_tcnt <= '0;
            if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_tx       <= r_tx_par;
              r_tx_state <= PARITY;
`else
              r_tx       <= 1'b1;
              r_tx_state <= STOP;
`endif
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_tx     <= r_tx_sh[0];
              r_tx_sh  <= r_tx_sh >> 1;
            end
          end else if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_tcnt  <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= STOP;
          end else if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_tx_bit_end) begin
            r_tx_tcnt <= '0;
            if (w_pop) begin
              r_tx_sh    <= w_fifo_dout;
              r_tx_arm   <= 1'b0;
              r_tx       <= 1'b0;
              r_tx_state <= START;
            end else begin
              r_tx_state <= IDLE;
            end
          end else if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic                 w_rx_fall, w_rx_sample;
  logic [OSW-1:0]       r_rx_tcnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_sh;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_rx_err;

  assign w_rx_fall   = r_rx_prev & ~r_rx_s2;
  assign w_rx_sample = w_tick & (r_rx_tcnt == OS_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

`ifdef UART_PARITY_EN
  logic r_rx_pbit;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_pbit  <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        IDLE: begin
          if (w_rx_fall) begin
            r_rx_tcnt  <= '0;
            r_rx_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_rx_tcnt == OS_HALF) begin
              r_rx_tcnt <= '0;
              r_rx_bit  <= '0;
              r_rx_state <= r_rx_s2 ? IDLE : DATA;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_rx_sample) begin
            r_rx_tcnt <= '0;
            r_rx_sh   <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_rx_state <= PARITY;
`else
              r_rx_state <= STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_rx_sample) begin
            r_rx_tcnt  <= '0;
            r_rx_pbit  <= r_rx_s2;
            r_rx_state <= STOP;
          end else if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_rx_sample) begin
            r_rx_tcnt  <= '0;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
`ifdef UART_PARITY_EN
            r_rx_err   <= ~r_rx_s2 | (r_rx_pbit ^ (^r_rx_sh));
`else
            r_rx_err   <= ~r_rx_s2;
`endif
            r_rx_state <= IDLE;
          end else if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_full  = w_full;
  assign tx_busy  = (r_tx_state != IDLE) | ~w_empty;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign rx_err   = r_rx_err;
  assign rx_busy  = (r_rx_state != IDLE);

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core at 16 MHz / 115200 baud (128 cycles per bit).
module tb_uart_fifo_core;
  localparam int CLK_HZ  = 16_000_000;
  localparam int DB      = 8;
  localparam int DEPTH   = 8;
  localparam int OS      = 16;
  localparam int BIT_CYC = 128;
`ifdef UART_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    baud_sel = 4'd7;
  logic          wr_i = 1'b0;
  logic [DB-1:0] dat_i = '0;
  logic          tx_full, tx_busy, tx, rx, rx_valid, rx_busy, rx_err;
  logic [DB-1:0] rx_data;
  logic          loop = 1'b0;
  logic          rx_drv = 1'b1;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_core #(
    .CLK_HZ    (CLK_HZ),
    .DATA_BITS (DB),
    .TX_DEPTH  (DEPTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .baud_sel(baud_sel),
    .wr_i    (wr_i),
    .dat_i   (dat_i),
    .tx_full (tx_full),
    .tx_busy (tx_busy),
    .tx      (tx),
    .rx      (rx),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_busy (rx_busy),
    .rx_err  (rx_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  logic [DB:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      rx_q.push_back({rx_err, rx_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line level of frame slot idx: start, data LSB first, [even parity], stop.
  function automatic logic exp_bit(input logic [DB-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
`ifdef UART_PARITY_EN
    if (idx == DB + 1) return logic'($countones(w) % 2);
`endif
    return 1'b1;
  endfunction

  task automatic write_word(input logic [DB-1:0] w);
    dat_i = w;
    wr_i  = 1'b1;
    @(negedge clk);
    wr_i  = 1'b0;
  endtask

  task automatic expect_rx(input string tag, input logic [DB-1:0] w, input logic err);
    logic [DB:0] v;
    for (int i = 0; i < 400 && rx_q.size() == 0; i++) @(negedge clk);
    check({tag, "_rx_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      v = rx_q.pop_front();
      check({tag, "_rx_data"}, v[DB-1:0], w);
      check({tag, "_rx_err"}, v[DB], err);
    end
  endtask

  task automatic tx_loopback(input logic [DB-1:0] w, input string tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    write_word(w);
    while (!seen && lat < 64) begin
      if (tx === 1'b0) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    // pop one cycle after the write, then the start bit at the next tick (1..8 cycles)
    check({tag, "_start_latency_ok"}, (seen && lat >= 2 && lat <= 9), 1);
    if (seen) begin
      cycles(BIT_CYC / 2);
      check({tag, "_start_centre"}, tx, 1'b0);
      cycles(BIT_CYC / 2 - 1);
      check({tag, "_start_last_cycle"}, tx, 1'b0);
      cycles(1);
      check({tag, "_bit0_edge"}, tx, exp_bit(w, 1));
      cycles(BIT_CYC / 2);
      check({tag, "_slot1"}, tx, exp_bit(w, 1));
      for (int i = 2; i < NBITS; i++) begin
        cycles(BIT_CYC);
        check({tag, "_slot", $sformatf("%0d", i)}, tx, exp_bit(w, i));
      end
    end
    expect_rx(tag, w, 1'b0);
    for (int i = 0; i < 400 && tx_busy !== 1'b0; i++) @(negedge clk);
    check({tag, "_tx_busy_end"}, tx_busy, 1'b0);
  endtask

  task automatic rx_frame(input logic [DB-1:0] w, input logic bad_par,
                          input logic stop_v, input string tag);
    rx_drv = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < DB; i++) begin
      rx_drv = w[i];
      cycles(BIT_CYC);
    end
`ifdef UART_PARITY_EN
    rx_drv = logic'($countones(w) % 2) ^ bad_par;
    cycles(BIT_CYC);
`endif
    rx_drv = stop_v;
    cycles(BIT_CYC);
    rx_drv = 1'b1;
    cycles(BIT_CYC / 2);
    expect_rx(tag, w, ~stop_v | bad_par);
  endtask

  initial begin
    logic [DB-1:0] w;
    logic [DB-1:0] acc[$];
    logic          full_before;
    int            v0;

    // reset state
    rst = 1'b0; loop = 1'b0; rx_drv = 1'b1; wr_i = 1'b0; baud_sel = 4'd7;
    cycles(5);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_rx_err", rx_err, 1'b0);
    rst = 1'b1;
    cycles(4);

    // loopback: directed then random words
    loop = 1'b1;
    tx_loopback(8'hA5, "a5");
    for (int i = 0; i < 3; i++) begin
      w = DB'($urandom);
      tx_loopback(w, "rnd");
    end
`ifdef UART_PARITY_EN
    tx_loopback(8'h07, "par07");
`endif

    // burst of 10 writes into an idle transmitter
    acc.delete();
    for (int k = 1; k <= 10; k++) begin
      full_before = (acc.size() > DEPTH);
      check("burst_full_pre", tx_full, full_before);
      dat_i = DB'(k);
      wr_i  = 1'b1;
      @(negedge clk);
      if (!full_before) acc.push_back(DB'(k));
      check("burst_full_post", tx_full, acc.size() > DEPTH);
    end
    wr_i = 1'b0;
    for (int i = 0; i < 14000 && rx_q.size() < acc.size(); i++) @(negedge clk);
    check("burst_rx_count", rx_q.size(), acc.size());
    check("burst_tx_busy_tail", tx_busy, 1'b1);
    for (int i = 0; i < acc.size(); i++) begin
      if (rx_q.size() > 0) begin
        check("burst_rx_data", rx_q[0][DB-1:0], acc[i]);
        check("burst_rx_err", rx_q[0][DB], 1'b0);
        void'(rx_q.pop_front());
      end
    end
    for (int i = 0; i < 400 && tx_busy !== 1'b0; i++) @(negedge clk);
    check("burst_tx_busy_end", tx_busy, 1'b0);
    cycles(50);
    check("burst_no_extra", rx_q.size(), 0);

    // receiver driven directly
    loop = 1'b0;
    rx_drv = 1'b1;
    cycles(8);
    rx_frame(8'h3C, 1'b0, 1'b0, "frame_err");
    for (int i = 0; i < 2; i++) begin
      w = DB'($urandom);
      rx_frame(w, 1'b0, 1'b1, "rx_rnd");
    end
`ifdef UART_PARITY_EN
    rx_frame(8'h07, 1'b1, 1'b1, "par_err");
`endif

    // false start: 40-cycle low pulse
    v0 = n_valid;
    rx_drv = 1'b0;
    cycles(10);
    check("false_start_busy", rx_busy, 1'b1);
    cycles(30);
    rx_drv = 1'b1;
    cycles(200);
    check("false_start_idle", rx_busy, 1'b0);
    check("false_start_no_valid", n_valid, v0);

    // reset in the middle of a looped-back frame
    loop = 1'b1;
    cycles(4);
    write_word(DB'($urandom));
    cycles(400);
    check("midrst_pre_tx_busy", tx_busy, 1'b1);
    check("midrst_pre_rx_busy", rx_busy, 1'b1);
    v0 = n_valid;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_high", tx, 1'b1);
    check("midrst_tx_busy", tx_busy, 1'b0);
    check("midrst_rx_busy", rx_busy, 1'b0);
    cycles(3);
    rst = 1'b1;
    cycles(1600);
    check("midrst_no_valid", n_valid, v0);
    check("midrst_tx_idle", tx, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised, buffered UART core for the board-level UART designs: a TX FIFO, a start/data/stop transmitter, and a 16x-oversampled receiver, all clocked by the board clock. Data width, FIFO depth, clock frequency and oversampling ratio are generics. The baud-rate table and its 4-bit select are internal. Optional parity is compiled in by macro. It replaces the unbuffered UART plus external baud generator: writers may burst words without polling busy.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- DATA_BITS, 8, bits per frame, legal 5..8
- TX_DEPTH, 8, TX FIFO entries, power of two, >= 2
- OVERSAMPLE, 16, ticks per bit, even, >= 8
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- baud_sel  in  4  baud select: 0..9 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800; 10..15 = 9600
- wr_i  in  1  push dat_i into TX FIFO
- dat_i  in  DATA_BITS  word to transmit
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  FIFO non-empty or frame in progress
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous
- rx_valid  out  1  one-cycle pulse: rx_data/rx_err valid
- rx_data  out  DATA_BITS  last received word
- rx_busy  out  1  receive frame in progress
- rx_err  out  1  framing/parity error for current rx_valid

## Operation
- Tick generator: divisor = floor(CLK_HZ/(baud*OVERSAMPLE)), constants fixed at elaboration. Counter emits one-cycle tick every divisor cycles. baud_sel is registered only while both FSMs are IDLE. Changes mid-frame are deferred.
- TX FIFO: wr_i with tx_full=0 pushes. wr_i with tx_full=1 is dropped with no state change. tx_full is evaluated before a same-cycle pop, so a write into a full FIFO is dropped even if a pop occurs that cycle. A word pushed in cycle n is poppable in cycle n+1.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE pops when the FIFO is non-empty.
  - Every bit lasts OVERSAMPLE ticks. DATA is sent LSB first, DATA_BITS bits. STOP is 1 bit, high.
  - After STOP, pops the next word directly if available. Otherwise returns to IDLE.
- RX: two-flop synchroniser, reset state high.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: falling edge on the synchronised line -> START.
  - START: waits OVERSAMPLE/2 ticks. If the line is high there, it is a false start: return to IDLE with no rx_valid.
  - Then samples each bit at its centre, OVERSAMPLE ticks apart.
  - STOP sample: rx_data updates, rx_valid pulses 1 cycle, rx_err=1 if the stop sample is 0 (or parity mismatch). Data is delivered even on error.
  - Returns to IDLE the next cycle.
- rx_err changes only on rx_valid cycles.
- rx_busy is high in START through STOP. tx_busy = (FSM != IDLE) | FIFO non-empty.

## Timing
- Reset values: tx=1, tx_full=0, tx_busy=0, rx_valid=0, rx_data=0, rx_busy=0, rx_err=0. FIFO is emptied, both FSMs go to IDLE, tick counter = 0, baud register = 3 (9600).
- Reset mid-frame aborts both directions immediately: tx returns high the cycle after rst is sampled low, and no rx_valid is issued.
- Write-to-start latency with an idle TX: pop 1 cycle after wr_i, then tx falls at the next tick.
- Frame length: (2 + DATA_BITS [+1 parity]) * OVERSAMPLE ticks.
- RX output latency: rx_valid occurs 2 sync cycles + 1 cycle after the stop-bit centre tick.

## Configuration
- UART_PARITY_EN defined: a PARITY state is inserted in both FSMs, using even parity over the data bits. TX sends the parity bit after the data bits. RX checks it, and a mismatch ORs into rx_err.
- UART_PARITY_EN undefined: no parity state, no parity logic.

## Test plan
CLK_HZ=16_000_000, baud_sel=7: divisor=8, 128 cycles/bit, tx looped to rx unless noted.
- Reset: hold rst=0 for 5 cycles with rx=1 -> tx=1, all status outputs 0. Assert rst=0 mid-frame -> tx=1 next cycle, no rx_valid.
- Loopback 0xA5 -> tx low 128 cycles, then bits 1,0,1,0,0,1,0,1, then stop high. One rx_valid pulse with rx_data=0xA5, rx_err=0.
- wr_i for 10 consecutive cycles with 0x01..0x0A, TX_DEPTH=8 -> tx_full rises after the 9th write. 0x0A is dropped. rx receives 0x01..0x09 in order, and tx_busy falls after the last stop bit.
- Drive rx with 0x3C and stop bit 0 -> rx_valid, rx_data=0x3C, rx_err=1.
- Drive an rx low pulse of 40 cycles (< 64 half-bit) -> rx_busy pulses, no rx_valid.
- With UART_PARITY_EN: send 0x07 -> parity bit 1. Inject 0x07 with parity 0 -> rx_valid, rx_err=1.
